// File: rtl/adder37_rr_scheduler.sv
// Round-robin scheduler that shares one 37+1-bit ripple-carry adder among four requesters.
// It captures the winning operands, spends one cycle on the add, and holds the result until the consumer accepts it.
module adder37_rr_scheduler (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [147:0] req_a,
    input  logic [3:0]   req_b,
    output logic [3:0]   req_ready,
    output logic         rsp_valid,
    output logic [37:0]  rsp_sum,
    output logic [1:0]   rsp_id,
    input  logic         rsp_ready,
    output logic         busy
);

    localparam int NREQ = 4;
    localparam int AW   = 37;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    ptr;
    logic [AW-1:0] op_a;
    logic          op_b;
    logic [1:0]    op_id;
    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [AW-1:0] a_sel;
    logic          b_sel;
    logic [AW:0]   sum;
    logic [AW:0]   carry;

    // Search upward from ptr with wrap; the 2-bit index wraps on its own.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[ptr + 2'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 2'(i)) begin
                a_sel = req_a[i*AW +: AW];
                b_sel = req_b[i];
            end
        end
    end

    // B is a single bit, so the ripple chain reduces to a half-adder per bit with B as carry-in.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = op_b;
        for (int i = 0; i < AW; i++) begin
            sum[i]     = op_a[i] ^ carry[i];
            carry[i+1] = op_a[i] & carry[i];
        end
        sum[AW] = carry[AW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = ADD;
            ADD:     state_next = HOLD;
            HOLD:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operands are frozen at grant time so later input changes cannot disturb the in-flight add.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                op_a  <= a_sel;
                op_b  <= b_sel;
                op_id <= grant_idx;
                ptr   <= grant_idx + 2'd1;
            end
            if (state == ADD) begin
                rsp_sum   <= sum;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder37_rr_scheduler.sv
// Directed bench for adder37_rr_scheduler: stimulus pushes expected responses, a monitor pops them on each accept.
module tb_adder37_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [147:0] req_a;
    logic [3:0]   req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [37:0]  rsp_sum;
    logic [1:0]   rsp_id;
    logic         rsp_ready;
    logic         busy;

    typedef struct packed {
        logic [1:0]  id;
        logic [37:0] sum;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    adder37_rr_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp actual id=%0d sum=%0h required none", rsp_id, rsp_sum);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
            end
        end
    end

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [36:0] a, input logic b,
                                 input logic [37:0] exp_sum, output int gcyc);
        logic       found;
        logic [3:0] onehot;
        onehot = 4'b0001 << id;
        req_a[id*37 +: 37] = a;
        req_b[id]          = b;
        req_valid[id]      = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout actual=none required=%0d", id);
        end else begin
            checkOutput("grant", 64'(req_ready), 64'(onehot));
            exp_q.push_back({2'(id), exp_sum});
        end
        gcyc = cyc;
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic waitIdle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout actual busy=%0b required busy=0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         gcyc;
        int         got;
        int         last;
        logic [3:0] onehot;
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [37:0] rr_sum [4] = '{38'h0B, 38'h14, 38'h20_0000_0000, 38'h01};

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_sum", 64'(rsp_sum), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single request latency");
        applyStimulus(1, 37'h0_0000_0005, 1'b1, 38'h6, gcyc);
        @(negedge clk);
        checkOutput("lat_t1_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("lat_t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("lat_t2_rsp_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        checkOutput("lat_t3_busy", 64'(busy), 64'd0);
        checkOutput("lat_t3_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] carry boundary");
        applyStimulus(0, 37'h1F_FFFF_FFFF, 1'b1, 38'h20_0000_0000, gcyc);
        waitIdle();
        applyStimulus(3, 37'h1F_FFFF_FFFF, 1'b0, 38'h1F_FFFF_FFFF, gcyc);
        waitIdle();

        $display("[TB] round-robin fairness");
        resetDut();
        req_a[0*37 +: 37] = 37'h0A;          req_b[0] = 1'b1;
        req_a[1*37 +: 37] = 37'h14;          req_b[1] = 1'b0;
        req_a[2*37 +: 37] = 37'h1F_FFFF_FFFF; req_b[2] = 1'b1;
        req_a[3*37 +: 37] = 37'h00;          req_b[3] = 1'b1;
        req_valid = 4'hF;
        got  = 0;
        last = 0;
        for (int n = 0; n < 60 && got < 5; n++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                onehot = 4'b0001 << order[got];
                checkOutput("rr_grant", 64'(req_ready), 64'(onehot));
                if (got > 0) checkOutput("rr_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                exp_q.push_back({order[got], rr_sum[order[got]]});
                got++;
            end
        end
        if (got < 5) begin
            checks++;
            errors++;
            $display("[TB] FAIL rr_timeout actual=%0d required=5", got);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        waitIdle();

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(2, 37'h12_3456_789A, 1'b1, 38'h12_3456_789B, gcyc);
        req_a[0*37 +: 37] = 37'h07;
        req_b[0]          = 1'b0;
        req_valid[0]      = 1'b1;
        @(negedge clk);
        checkOutput("bp_add_req_ready", 64'(req_ready), 64'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_rsp_sum", 64'(rsp_sum), 64'h12_3456_789B);
            checkOutput("bp_rsp_id", 64'(rsp_id), 64'd2);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        checkOutput("bp_next_grant", 64'(req_ready), 64'h1);
        exp_q.push_back({2'd0, 38'h07});
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        waitIdle();

        $display("[TB] operand isolation");
        applyStimulus(2, 37'h0_0000_00FF, 1'b0, 38'hFF, gcyc);
        req_a[2*37 +: 37] = 37'h1_0000_0000;
        req_b[2]          = 1'b1;
        waitIdle();

        $display("[TB] reset mid-operation");
        req_a[0*37 +: 37] = 37'h03;
        req_b[0]          = 1'b0;
        req_valid         = 4'b0001;
        @(negedge clk);
        checkOutput("mid_grant", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        rst               = 1'b1;
        req_valid         = 4'b1010;
        req_a[1*37 +: 37] = 37'h44;
        req_b[1]          = 1'b1;
        req_a[3*37 +: 37] = 37'h09;
        req_b[3]          = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("mid_busy", 64'(busy), 64'd0);
        checkOutput("mid_post_grant", 64'(req_ready), 64'h2);
        exp_q.push_back({2'd1, 38'h45});
        @(posedge clk);
        #1;
        req_valid = '0;
        waitIdle();

        repeat (4) @(posedge clk);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
